// File: rtl/vga_timing_rx_if.sv
// Pixel-port bundle: raw VGA sync/RGB from a generator into vga_timing_rx,
// and the recovered pixel stream with lock status coming back out.
interface vga_timing_rx_if #(
   parameter int COLOR_BIT_DEPTH = 8,
   parameter int HOR_BIT_DEPTH   = 12,
   parameter int VER_BIT_DEPTH   = 12
);
   logic                       vga_hsync;
   logic                       vga_vsync;
   logic [COLOR_BIT_DEPTH-1:0] vga_red;
   logic [COLOR_BIT_DEPTH-1:0] vga_green;
   logic [COLOR_BIT_DEPTH-1:0] vga_blue;

   // pix_valid qualifies pix_x/pix_y/pix_* for that one cycle only; there is no
   // ready: the stream runs at pixel rate and the consumer must take every beat.
   logic                       pix_valid;
   logic [HOR_BIT_DEPTH-1:0]   pix_x;
   logic [VER_BIT_DEPTH-1:0]   pix_y;
   logic [COLOR_BIT_DEPTH-1:0] pix_red;
   logic [COLOR_BIT_DEPTH-1:0] pix_green;
   logic [COLOR_BIT_DEPTH-1:0] pix_blue;
   logic                       line_start;
   logic                       frame_start;
   logic                       locked;
   logic [7:0]                 err_cnt;
   logic [1:0]                 rx_state;

   modport master (
      output vga_hsync, vga_vsync, vga_red, vga_green, vga_blue,
      input  pix_valid, pix_x, pix_y, pix_red, pix_green, pix_blue,
      input  line_start, frame_start, locked, err_cnt, rx_state
   );

   modport slave (
      input  vga_hsync, vga_vsync, vga_red, vga_green, vga_blue,
      output pix_valid, pix_x, pix_y, pix_red, pix_green, pix_blue,
      output line_start, frame_start, locked, err_cnt, rx_state
   );
endinterface

// File: rtl/vga_timing_rx.sv
// VGA timing receiver: recovers pixel coordinates from hsync/vsync, validates the
// mode timing, and emits a locked pixel stream two clocks after the port sample.
module vga_timing_rx #(
   parameter int HOR_FRONT_PORCH = 16,
   parameter int HOR_SYNC_PULSE  = 96,
   parameter int HOR_BACK_PORCH  = 48,
   parameter int HOR_RES         = 640,
   parameter int VER_FRONT_PORCH = 10,
   parameter int VER_SYNC_PULSE  = 2,
   parameter int VER_BACK_PORCH  = 33,
   parameter int VER_RES         = 480,
   parameter int COLOR_BIT_DEPTH = 8,
   parameter int HOR_BIT_DEPTH   = 12,
   parameter int VER_BIT_DEPTH   = 12
) (
   input logic            clk,
   input logic            reset,
   vga_timing_rx_if.slave bus
);
   localparam int H_DATA  = HOR_SYNC_PULSE + HOR_BACK_PORCH;
   localparam int H_TOTAL = H_DATA + HOR_RES + HOR_FRONT_PORCH;
   localparam int V_DATA  = VER_SYNC_PULSE + VER_BACK_PORCH;
   localparam int V_TOTAL = V_DATA + VER_RES + VER_FRONT_PORCH;

   localparam logic [HOR_BIT_DEPTH-1:0] H_LAST  = HOR_BIT_DEPTH'(H_TOTAL - 1);
   localparam logic [HOR_BIT_DEPTH-1:0] H_SYNC  = HOR_BIT_DEPTH'(HOR_SYNC_PULSE);
   localparam logic [HOR_BIT_DEPTH-1:0] H_START = HOR_BIT_DEPTH'(H_DATA);
   localparam logic [HOR_BIT_DEPTH-1:0] H_END   = HOR_BIT_DEPTH'(H_DATA + HOR_RES);
   localparam logic [VER_BIT_DEPTH-1:0] V_LAST  = VER_BIT_DEPTH'(V_TOTAL - 1);
   localparam logic [VER_BIT_DEPTH-1:0] V_START = VER_BIT_DEPTH'(V_DATA);
   localparam logic [VER_BIT_DEPTH-1:0] V_END   = VER_BIT_DEPTH'(V_DATA + VER_RES);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      ALIGN  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t state;

   logic                       hs1, hs1_d, vs1, vs1_d;
   logic [COLOR_BIT_DEPTH-1:0] red1, green1, blue1;
   logic [HOR_BIT_DEPTH-1:0]   h_pos_q, h_pos;
   logic [VER_BIT_DEPTH-1:0]   v_pos_q, v_pos;
   logic                       frame_pending;
   logic                       hfall, hrise, vfall, frame_hfall;
   logic                       violation, in_window, pix_ok;

   logic                       pix_valid_q, line_start_q, frame_start_q, locked_q;
   logic [HOR_BIT_DEPTH-1:0]   pix_x_q;
   logic [VER_BIT_DEPTH-1:0]   pix_y_q;
   logic [COLOR_BIT_DEPTH-1:0] pix_red_q, pix_green_q, pix_blue_q;
   logic [7:0]                 err_cnt_q;

   // h_pos/v_pos describe the sample currently in stage 1; the _q copies are
   // the previous sample's values, which the end-of-line/frame checks need.
   always_comb begin
      hfall       = hs1_d & ~hs1;
      hrise       = ~hs1_d & hs1;
      vfall       = vs1_d & ~vs1;
      frame_hfall = hfall & (frame_pending | vfall);
      h_pos       = hfall ? '0 :
                    (h_pos_q == '1) ? h_pos_q : h_pos_q + HOR_BIT_DEPTH'(1);
      v_pos       = frame_hfall ? '0 :
                    (hfall && v_pos_q != '1) ? v_pos_q + VER_BIT_DEPTH'(1) : v_pos_q;
      violation   = (state != SEARCH) &&
                    ((hfall && h_pos_q != H_LAST) ||
                     (hrise && h_pos != H_SYNC) ||
                     (frame_hfall && v_pos_q != V_LAST));
      in_window   = (h_pos >= H_START) && (h_pos < H_END) &&
                    (v_pos >= V_START) && (v_pos < V_END);
      pix_ok      = (state == LOCKED) && !violation && in_window;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hs1           <= 1'b1;
         hs1_d         <= 1'b1;
         vs1           <= 1'b1;
         vs1_d         <= 1'b1;
         red1          <= '0;
         green1        <= '0;
         blue1         <= '0;
         h_pos_q       <= '0;
         v_pos_q       <= '0;
         frame_pending <= 1'b0;
         state         <= SEARCH;
         locked_q      <= 1'b0;
         err_cnt_q     <= '0;
         pix_valid_q   <= 1'b0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         pix_red_q     <= '0;
         pix_green_q   <= '0;
         pix_blue_q    <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hs1           <= bus.vga_hsync;
         hs1_d         <= hs1;
         vs1           <= bus.vga_vsync;
         vs1_d         <= vs1;
         red1          <= bus.vga_red;
         green1        <= bus.vga_green;
         blue1         <= bus.vga_blue;
         h_pos_q       <= h_pos;
         v_pos_q       <= v_pos;
         frame_pending <= frame_hfall ? 1'b0 : (frame_pending | vfall);

         case (state)
            SEARCH: begin
               if (frame_hfall) state <= ALIGN;
            end
            ALIGN: begin
               if (violation) begin
                  state <= SEARCH;
               end else if (frame_hfall) begin
                  state    <= LOCKED;
                  locked_q <= 1'b1;
               end
            end
            LOCKED: begin
               if (violation) begin
                  state    <= SEARCH;
                  locked_q <= 1'b0;
                  if (err_cnt_q != 8'hff) err_cnt_q <= err_cnt_q + 8'd1;
               end
            end
            default: begin
               state    <= SEARCH;
               locked_q <= 1'b0;
            end
         endcase

         // Coordinates hold their last visible value across blanking.
         pix_valid_q <= pix_ok;
         if (pix_ok) begin
            pix_x_q <= h_pos - H_START;
            pix_y_q <= v_pos - V_START;
         end
         pix_red_q     <= pix_ok ? red1   : '0;
         pix_green_q   <= pix_ok ? green1 : '0;
         pix_blue_q    <= pix_ok ? blue1  : '0;
         line_start_q  <= pix_ok && (h_pos == H_START);
         frame_start_q <= pix_ok && (h_pos == H_START) && (v_pos == V_START);
      end
   end

   assign bus.pix_valid   = pix_valid_q;
   assign bus.pix_x       = pix_x_q;
   assign bus.pix_y       = pix_y_q;
   assign bus.pix_red     = pix_red_q;
   assign bus.pix_green   = pix_green_q;
   assign bus.pix_blue    = pix_blue_q;
   assign bus.line_start  = line_start_q;
   assign bus.frame_start = frame_start_q;
   assign bus.locked      = locked_q;
   assign bus.err_cnt     = err_cnt_q;
   assign bus.rx_state    = state;
endmodule

// File: tb/tb_vga_timing_rx.sv
// Bench for vga_timing_rx on a tiny 9x6 mode: random colours and vsync phase,
// timing faults, mid-frame reset and error-counter saturation.
module tb_vga_timing_rx;
   localparam int HFP = 1, HSP = 2, HBP = 2, HRES = 4;
   localparam int VFP = 1, VSP = 1, VBP = 1, VRES = 3;
   localparam int H_DATA = HSP + HBP;
   localparam int HT     = H_DATA + HRES + HFP;
   localparam int V_DATA = VSP + VBP;
   localparam int VT     = V_DATA + VRES + VFP;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   vga_timing_rx_if #(.COLOR_BIT_DEPTH(8), .HOR_BIT_DEPTH(12), .VER_BIT_DEPTH(12)) bus ();

   vga_timing_rx #(
      .HOR_FRONT_PORCH(HFP), .HOR_SYNC_PULSE(HSP), .HOR_BACK_PORCH(HBP), .HOR_RES(HRES),
      .VER_FRONT_PORCH(VFP), .VER_SYNC_PULSE(VSP), .VER_BACK_PORCH(VBP), .VER_RES(VRES),
      .COLOR_BIT_DEPTH(8), .HOR_BIT_DEPTH(12), .VER_BIT_DEPTH(12)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int          n_checks = 0;
   int          n_fail = 0;
   int          frame_valid_cnt = 0;
   logic [63:0] exp_q[$];

   // Reference model state: positions are counted as elapsed samples since the
   // last line start and lines since the last frame start.
   int          m_t = 0, m_t_hfall = 0, m_v = 0, m_err = 0, m_phase = 0;
   bit          m_prev_hs = 1'b1, m_prev_vs = 1'b1, m_pend = 1'b0;
   logic [11:0] m_x = '0, m_y = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] pack(input logic v, input logic [11:0] x, input logic [11:0] y,
                                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                        input logic ls, input logic fs, input logic lk,
                                        input logic [7:0] err);
      return {4'b0, v, x, y, r, g, b, ls, fs, lk, err};
   endfunction

   function automatic logic [63:0] observed();
      return pack(bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_red, bus.pix_green, bus.pix_blue,
                  bus.line_start, bus.frame_start, bus.locked, bus.err_cnt);
   endfunction

   task automatic model_reset();
      m_prev_hs = 1'b1;
      m_prev_vs = 1'b1;
      m_pend    = 1'b0;
      m_phase   = 0;
      m_err     = 0;
      m_v       = 0;
      m_x       = '0;
      m_y       = '0;
      m_t_hfall = m_t;
   endtask

   task automatic model_step(input bit hs, input bit vs, input logic [7:0] r, input logic [7:0] g,
                             input logic [7:0] b, output logic [63:0] e);
      bit hfall, hrise, vfall, fs, viol, valid, ls, frm;
      int prev_h, prev_v, h;
      hfall  = m_prev_hs && !hs;
      hrise  = !m_prev_hs && hs;
      vfall  = m_prev_vs && !vs;
      m_pend = m_pend || vfall;
      fs     = hfall && m_pend;
      prev_h = m_t - 1 - m_t_hfall;
      prev_v = m_v;
      if (hfall) m_t_hfall = m_t;
      h = m_t - m_t_hfall;
      if (fs) begin
         m_v    = 0;
         m_pend = 1'b0;
      end else if (hfall) begin
         m_v++;
      end
      viol = (m_phase != 0) &&
             ((hfall && prev_h != HT - 1) || (hrise && h != HSP) || (fs && prev_v != VT - 1));
      valid = (m_phase == 2) && !viol && h >= H_DATA && h < H_DATA + HRES &&
              m_v >= V_DATA && m_v < V_DATA + VRES;
      if (viol) begin
         if (m_phase == 2 && m_err < 255) m_err++;
         m_phase = 0;
      end else if (fs) begin
         m_phase = (m_phase == 0) ? 1 : 2;
      end
      if (valid) begin
         m_x = 12'(h - H_DATA);
         m_y = 12'(m_v - V_DATA);
      end
      ls  = valid && (h == H_DATA);
      frm = ls && (m_v == V_DATA);
      e = pack(valid, m_x, m_y, valid ? r : 8'd0, valid ? g : 8'd0, valid ? b : 8'd0,
               ls, frm, m_phase == 2, 8'(m_err));
      m_prev_hs = hs;
      m_prev_vs = vs;
      m_t++;
   endtask

   // One pixel clock: score the output due from two samples ago, then drive.
   task automatic tick(input bit hs, input bit vs, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input bit rst);
      logic [63:0] e;
      @(negedge clk);
      if (exp_q.size() >= 2) begin
         e = exp_q.pop_front();
         check("pix_stream", observed(), e);
      end
      if (bus.pix_valid) frame_valid_cnt++;
      reset         = rst;
      bus.vga_hsync = hs;
      bus.vga_vsync = vs;
      bus.vga_red   = r;
      bus.vga_green = g;
      bus.vga_blue  = b;
      if (rst) begin
         model_reset();
         if (exp_q.size() > 0) exp_q[exp_q.size()-1] = '0;
         exp_q.push_back('0);
      end else begin
         model_step(hs, vs, r, g, b, e);
         exp_q.push_back(e);
      end
   endtask

   task automatic send_line(input int v, input int extra, input int hsw, input int vs_fall_col);
      bit hs, vs;
      for (int c = 0; c < HT + extra; c++) begin
         hs = (c >= hsw);
         vs = !((v < VSP) || (vs_fall_col >= 0 && c >= vs_fall_col));
         tick(hs, vs, 8'(c - H_DATA), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
      end
   endtask

   task automatic send_frame(input int long_line, input int short_line, input bit early_vs);
      int col;
      frame_valid_cnt = 0;
      for (int v = 0; v < VT; v++) begin
         col = (v == VT - 1 && early_vs) ? int'($urandom_range(HT - 1, HSP + 1)) : -1;
         send_line(v, (v == long_line) ? 1 : 0, (v == short_line) ? HSP - 1 : HSP, col);
      end
   endtask

   initial begin
      model_reset();
      bus.vga_hsync = 1'b1;
      bus.vga_vsync = 1'b1;
      bus.vga_red   = '0;
      bus.vga_green = '0;
      bus.vga_blue  = '0;
      repeat (3) tick(1'b1, 1'b1, 8'd0, 8'd0, 8'd0, 1'b1);
      check("reset_outputs", observed(), 64'd0);

      // Clean frames: ALIGN after the first frame start, LOCKED after the second.
      for (int f = 0; f < 3; f++) begin
         send_frame(-1, -1, 1'($urandom_range(0, 1)));
         if (f == 0) check("valid_before_lock", 64'(frame_valid_cnt), 64'd0);
         else        check("valid_per_frame", 64'(frame_valid_cnt), 64'(HRES * VRES));
      end
      check("locked_after_lock", 64'(bus.locked), 64'd1);

      // One line one clock too long while locked.
      send_frame(1, -1, 1'b0);
      check("err_after_long_line", 64'(bus.err_cnt), 64'd1);
      check("unlocked_after_long_line", 64'(bus.locked), 64'd0);
      send_frame(-1, -1, 1'b0);
      check("valid_while_relocking", 64'(frame_valid_cnt), 64'd0);
      send_frame(-1, -1, 1'b1);
      check("valid_after_relock", 64'(frame_valid_cnt), 64'(HRES * VRES));
      check("locked_after_relock", 64'(bus.locked), 64'd1);

      // Single-clock reset in the middle of a locked frame.
      for (int v = 0; v < 3; v++) send_line(v, 0, HSP, -1);
      tick(1'b1, 1'b1, 8'd0, 8'd0, 8'd0, 1'b1);
      for (int v = 3; v < VT; v++) send_line(v, 0, HSP, -1);
      check("err_after_reset", 64'(bus.err_cnt), 64'd0);
      check("unlocked_after_reset", 64'(bus.locked), 64'd0);

      // Short hsync pulse while aligning: back to SEARCH without counting an error.
      send_frame(-1, 2, 1'b0);
      check("err_after_short_hsync", 64'(bus.err_cnt), 64'd0);
      check("unlocked_after_short_hsync", 64'(bus.locked), 64'd0);
      send_frame(-1, -1, 1'b0);
      send_frame(-1, -1, 1'b0);
      check("locked_after_full_frame", 64'(bus.locked), 64'd1);
      check("valid_after_full_frame", 64'(frame_valid_cnt), 64'(HRES * VRES));

      // 300 lock losses: err_cnt saturates.
      for (int i = 0; i < 300; i++) begin
         send_frame(0, -1, 1'b0);
         if (i == 0) check("err_first_loss", 64'(bus.err_cnt), 64'd1);
         send_frame(-1, -1, 1'($urandom_range(0, 1)));
      end
      check("err_saturated", 64'(bus.err_cnt), 64'd255);

      repeat (3) tick(1'b1, 1'b1, 8'd0, 8'd0, 8'd0, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
